// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Funct3 codes, FSM states and access checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RESP
  } lsu_state_t;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic half_bad;
    logic word_bad;
    half_bad = (funct3[1:0] == 2'b01) && off[0];
    word_bad = (funct3[1:0] == 2'b10) && (off != 2'b00);
    return half_bad || word_bad;
  endfunction

  function automatic logic is_illegal(
    input logic [2:0] funct3,
    input logic       write
  );
    logic bad_code;
    bad_code = (funct3 == 3'b011) || (funct3 == 3'b110) ||
               (funct3 == 3'b111);
    return bad_code || (write && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle and data-memory port.
// master drives the request side of each bus.
interface lsu_if #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [SIZE-1:0]       req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [SIZE-1:0]       resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface mem_if #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH+1:0] mem_address;
  logic [2:0]            mem_funct3;
  logic [SIZE-1:0]       mem_w_data;
  logic                  mem_write;
  logic [SIZE-1:0]       mem_data_out;

  modport master (
    output mem_address, mem_funct3, mem_w_data, mem_write,
    input  mem_data_out
  );

  modport slave (
    input  mem_address, mem_funct3, mem_w_data, mem_write,
    output mem_data_out
  );
endinterface

// File: rtl/lsu_load_extract.sv
// Lane select and sign/zero extension of a loaded word.
// Little-endian: byte k sits at bits [8k+7:8k].
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  // pick the addressed lane, then extend by access type
  always_comb begin
    b      = word[{offset, 3'b000} +: 8];
    h      = offset[1] ? word[31:16] : word[15:0];
    result = word;
    unique case (1'b1)
      (funct3 == F3_B):  result = {{24{b[7]}}, b};
      (funct3 == F3_BU): result = {24'h0, b};
      (funct3 == F3_H):  result = {{16{h[15]}}, h};
      (funct3 == F3_HU): result = {16'h0, h};
      default:           result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator.
// Checks alignment, drives the memory port, extends loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave core,
  mem_if.master mem
);

  lsu_state_t            state;
  lsu_state_t            nxt;
  logic [ADDR_WIDTH+1:0] addr;
  logic [2:0]            f3;
  logic                  wr;
  logic                  accept;
  logic                  bad;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [SIZE-1:0]       rdata_q;
  logic                  err_q;
  logic [SIZE-1:0]       ext;

  assign addr = core.req_addr;
  assign f3   = core.req_funct3;
  assign wr   = core.req_write;

  assign accept = (state == IDLE) && core.req_valid && !rst;
  assign bad    = is_misaligned(f3, addr[1:0]) || is_illegal(f3, wr);

  assign mem.mem_address = addr;
  assign mem.mem_funct3  = f3;
  assign mem.mem_w_data  = core.req_wdata;

  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

  lsu_load_extract u_extract (
    .word   (mem.mem_data_out),
    .funct3 (f3_q),
    .offset (off_q),
    .result (ext)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state: stores and errors skip LOAD_WAIT
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) nxt = (bad || wr) ? RESP : LOAD_WAIT;
      end
      LOAD_WAIT: nxt = RESP;
      RESP: begin
        if (core.resp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // handshake and write strobe; write only on a clean store accept
  always_comb begin
    core.req_ready  = 1'b0;
    core.resp_valid = 1'b0;
    mem.mem_write   = 1'b0;
    unique case (state)
      IDLE: begin
        core.req_ready = !rst;
        mem.mem_write  = accept && wr && !bad;
      end
      RESP:    core.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // response payload and load context; held stable through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      f3_q    <= F3_B;
      off_q   <= 2'b00;
    end else if (accept) begin
      rdata_q <= '0;
      err_q   <= bad;
      f3_q    <= f3;
      off_q   <= addr[1:0];
    end else if (state == LOAD_WAIT) begin
      rdata_q <= ext;
      err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Behavioural lane-masked RAM with registered read.
module tb_load_store_unit;

  logic clk;
  logic rst;
  logic tb_clr;
  int   checks;
  int   fails;
  int   wr_count;
  logic [31:0] ram [16];

  lsu_if #(.SIZE(32), .ADDR_WIDTH(4)) li ();
  mem_if #(.SIZE(32), .ADDR_WIDTH(4)) mi ();

  load_store_unit #(.SIZE(32), .ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (li),
    .mem  (mi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [31:0] w;
    logic [3:0]  idx;
    idx = mi.mem_address[5:2];
    w   = ram[idx];
    if (tb_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      wr_count <= 0;
    end else if (mi.mem_write) begin
      case (mi.mem_funct3[1:0])
        2'b00: w[{mi.mem_address[1:0], 3'b000} +: 8] = mi.mem_w_data[7:0];
        2'b01: begin
          if (mi.mem_address[1]) w[31:16] = mi.mem_w_data[15:0];
          else                   w[15:0]  = mi.mem_w_data[15:0];
        end
        default: w = mi.mem_w_data;
      endcase
      ram[idx] <= w;
      wr_count <= wr_count + 1;
    end
    mi.mem_data_out <= ram[idx];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3,
                       input logic [5:0] a, input logic [31:0] wd);
    li.req_valid  = 1'b1;
    li.req_write  = w;
    li.req_funct3 = f3;
    li.req_addr   = a;
    li.req_wdata  = wd;
  endtask

  task automatic xact(input string tag, input logic w,
                      input logic [2:0] f3, input logic [5:0] a,
                      input logic [31:0] wd, input logic [31:0] ed,
                      input logic ee);
    int n;
    drive(w, f3, a, wd);
    li.resp_ready = 1'b1;
    #1;
    chk({tag, ".req_ready"}, li.req_ready, 1);
    chk({tag, ".mem_write"}, mi.mem_write, w && !ee);
    @(negedge clk);
    li.req_valid = 1'b0;
    n = 0;
    while (!li.resp_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, (w || ee) ? 0 : 1);
    chk({tag, ".rdata"}, li.resp_rdata, ed);
    chk({tag, ".err"}, li.resp_err, ee);
    @(negedge clk);
    chk({tag, ".back_idle"}, {li.req_ready, li.resp_valid}, 2'b10);
  endtask

  initial begin
    int wc;
    checks        = 0;
    fails         = 0;
    tb_clr        = 1'b1;
    rst           = 1'b1;
    li.resp_ready = 1'b0;
    drive(1'b1, 3'b010, 6'h00, 32'hFFFF_FFFF);
    @(negedge clk);
    tb_clr = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", li.req_ready, 0);
    chk("rst.mem_write", mi.mem_write, 0);
    chk("rst.resp_valid", li.resp_valid, 0);
    rst          = 1'b0;
    li.req_valid = 1'b0;
    @(negedge clk);
    chk("reset.req_ready", li.req_ready, 1);
    chk("reset.resp_valid", li.resp_valid, 0);
    chk("reset.resp_rdata", li.resp_rdata, 0);
    chk("reset.resp_err", li.resp_err, 0);
    chk("reset.ram0", ram[0], 0);

    xact("sw8", 1, 3'b010, 6'h08, 32'h1234_5678, 32'h0, 0);
    xact("lb9", 0, 3'b000, 6'h09, 32'h0, 32'h0000_0056, 0);
    xact("lbuB", 0, 3'b100, 6'h0B, 32'h0, 32'h0000_0012, 0);
    xact("lw8", 0, 3'b010, 6'h08, 32'h0, 32'h1234_5678, 0);

    xact("sb4", 1, 3'b000, 6'h04, 32'h0000_0080, 32'h0, 0);
    xact("lb4", 0, 3'b000, 6'h04, 32'h0, 32'hFFFF_FF80, 0);
    xact("lbu4", 0, 3'b100, 6'h04, 32'h0, 32'h0000_0080, 0);

    xact("shA", 1, 3'b001, 6'h0A, 32'h0000_BEEF, 32'h0, 0);
    xact("lw8b", 0, 3'b010, 6'h08, 32'h0, 32'hBEEF_5678, 0);
    xact("lhA", 0, 3'b001, 6'h0A, 32'h0, 32'hFFFF_BEEF, 0);
    xact("lhuA", 0, 3'b101, 6'h0A, 32'h0, 32'h0000_BEEF, 0);

    wc = wr_count;
    xact("sw6", 1, 3'b010, 6'h06, 32'hCAFE_F00D, 32'h0, 1);
    xact("lh3", 0, 3'b001, 6'h03, 32'h0, 32'h0, 1);
    xact("ld011", 0, 3'b011, 6'h00, 32'h0, 32'h0, 1);
    xact("sbu4", 1, 3'b100, 6'h04, 32'h0000_00AA, 32'h0, 1);
    chk("err.no_write", wr_count, wc);
    xact("lw4", 0, 3'b010, 6'h04, 32'h0, 32'h0000_0080, 0);

    drive(0, 3'b010, 6'h08, 32'h0);
    li.resp_ready = 1'b0;
    @(negedge clk);
    li.req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp.resp_valid", li.resp_valid, 1);
      chk("bp.rdata", li.resp_rdata, 32'hBEEF_5678);
      chk("bp.req_ready", li.req_ready, 0);
      @(negedge clk);
    end
    li.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp.release", {li.req_ready, li.resp_valid}, 2'b10);

    drive(0, 3'b010, 6'h08, 32'h0);
    @(negedge clk);
    li.req_valid = 1'b0;
    chk("rlw.in_wait", li.resp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rlw.no_resp", li.resp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rlw.idle", {li.req_ready, li.resp_valid}, 2'b10);

    wc = wr_count;
    rst = 1'b1;
    drive(1, 3'b010, 6'h08, 32'hDEAD_BEEF);
    #1;
    chk("rst_st.mem_write", mi.mem_write, 0);
    @(negedge clk);
    rst          = 1'b0;
    li.req_valid = 1'b0;
    #1;
    chk("rst_st.no_resp", li.resp_valid, 0);
    chk("rst_st.no_write", wr_count, wc);
    @(negedge clk);
    xact("lw8c", 0, 3'b010, 6'h08, 32'h0, 32'hBEEF_5678, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
